// File: rtl/conv33_window_gen.sv
// conv33_window_gen: streaming 3x3 window generator with two line buffers and a registered window.
module conv33_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] win_0,
    output logic [DW-1:0] win_1,
    output logic [DW-1:0] win_2,
    output logic [DW-1:0] win_3,
    output logic [DW-1:0] win_4,
    output logic [DW-1:0] win_5,
    output logic [DW-1:0] win_6,
    output logic [DW-1:0] win_7,
    output logic [DW-1:0] win_8,
    output logic          win_valid,
    output logic          frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0] col_q, col_d, pc;
    logic [RW-1:0] row_q, row_d, pr;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];
    logic          last_col, last_row, qual;
    logic          win_valid_q, frame_done_q;
    // sof forces the current pixel to (0,0) regardless of where the counters stand
    always_comb begin
        pc       = sof ? '0 : col_q;
        pr       = sof ? '0 : row_q;
        last_col = pc == CW'(IMG_W - 1);
        last_row = pr == RW'(IMG_H - 1);
        col_d    = last_col ? '0 : pc + 1'b1;
        row_d    = last_col ? (last_row ? '0 : pr + 1'b1) : pr;
        qual     = (pr >= RW'(2)) && (pc >= CW'(2));
        win_d    = '{win_q[1], win_q[2], lb1[pc],
                     win_q[4], win_q[5], lb0[pc],
                     win_q[7], win_q[8], pix_in};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= pix_valid && qual;
            frame_done_q <= pix_valid && qual && last_col && last_row;
            if (pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
            end
        end
    end
    // Line buffers are left unreset; stale entries can never reach a qualified window
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[pc] <= lb0[pc];
            lb0[pc] <= pix_in;
        end
    end
    assign win_0      = win_q[0];
    assign win_1      = win_q[1];
    assign win_2      = win_q[2];
    assign win_3      = win_q[3];
    assign win_4      = win_q[4];
    assign win_5      = win_q[5];
    assign win_6      = win_q[6];
    assign win_7      = win_q[7];
    assign win_8      = win_q[8];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv33_window_gen.sv
// tb_conv33_window_gen: directed checks of the window generator on a 4x4 and a 32x32 instance.
module tb_conv33_window_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] pix_a = '0, pix_b = '0;
    logic       valid_a = 1'b0, sof_a = 1'b0, valid_b = 1'b0, sof_b = 1'b0;
    logic [5:0] wa [9];
    logic [5:0] wb [9];
    logic       win_valid_a, frame_done_a, win_valid_b, frame_done_b;

    conv33_window_gen #(.IMG_W(4), .IMG_H(4), .DW(6)) dut_a (
        .clk(clk), .rst(rst), .pix_in(pix_a), .pix_valid(valid_a), .sof(sof_a),
        .win_0(wa[0]), .win_1(wa[1]), .win_2(wa[2]), .win_3(wa[3]), .win_4(wa[4]),
        .win_5(wa[5]), .win_6(wa[6]), .win_7(wa[7]), .win_8(wa[8]),
        .win_valid(win_valid_a), .frame_done(frame_done_a));

    conv33_window_gen dut_b (
        .clk(clk), .rst(rst), .pix_in(pix_b), .pix_valid(valid_b), .sof(sof_b),
        .win_0(wb[0]), .win_1(wb[1]), .win_2(wb[2]), .win_3(wb[3]), .win_4(wb[4]),
        .win_5(wb[5]), .win_6(wb[6]), .win_7(wb[7]), .win_8(wb[8]),
        .win_valid(win_valid_b), .frame_done(frame_done_b));

    int checks = 0;
    int errors = 0;
    logic [53:0] cap_a [$];
    bit          fd_a [$];
    int          idx_a [$];
    int          nacc_a;
    logic [53:0] cap_b [$];
    bit          fd_b [$];
    int          idx_b [$];
    int          nacc_b;
    int          img [32][32];

    function automatic logic [53:0] pk(input logic [5:0] w [9]);
        logic [53:0] v;
        for (int i = 0; i < 9; i++) v[53-6*i -: 6] = w[i];
        return v;
    endfunction

    function automatic logic [53:0] pk_int(input int a [9]);
        logic [53:0] v;
        for (int i = 0; i < 9; i++) v[53-6*i -: 6] = 6'(a[i]);
        return v;
    endfunction

    // window ending at (r,c) of a 4x4 frame whose pixel values are b + r*4 + c
    function automatic logic [53:0] exp4(input int b, input int r, input int c);
        logic [53:0] v;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v[53-6*(dr*3+dc) -: 6] = 6'(b + (r - 2 + dr) * 4 + (c - 2 + dc));
        return v;
    endfunction

    function automatic logic [53:0] exp32(input int r, input int c);
        logic [53:0] v;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v[53-6*(dr*3+dc) -: 6] = 6'(img[r-2+dr][c-2+dc]);
        return v;
    endfunction

    task automatic clear_a();
        cap_a.delete(); fd_a.delete(); idx_a.delete(); nacc_a = 0;
    endtask

    task automatic step_a(input logic v, input logic s, input int p);
        valid_a = v; sof_a = s; pix_a = 6'(p);
        @(posedge clk); #1;
        if (v) nacc_a++;
        if (win_valid_a) begin
            cap_a.push_back(pk(wa)); fd_a.push_back(frame_done_a); idx_a.push_back(nacc_a - 1);
        end
        valid_a = 1'b0; sof_a = 1'b0;
    endtask

    task automatic step_b(input logic v, input logic s, input int p);
        valid_b = v; sof_b = s; pix_b = 6'(p);
        @(posedge clk); #1;
        if (v) nacc_b++;
        if (win_valid_b) begin
            cap_b.push_back(pk(wb)); fd_b.push_back(frame_done_b); idx_b.push_back(nacc_b - 1);
        end
        valid_b = 1'b0; sof_b = 1'b0;
    endtask

    task automatic send_frame_a(input int b, input logic s);
        for (int i = 0; i < 16; i++) step_a(1'b1, s && i == 0, b + i);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({win_valid_a, frame_done_a, pk(wa), win_valid_b, frame_done_b, pk(wb)} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h required all zero", pk(wa), pk(wb));
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int f [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int l [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        clear_a();
        send_frame_a(0, 1'b1);
        step_a(1'b0, 1'b0, 0); step_a(1'b0, 1'b0, 0);
        checks++;
        if (cap_a.size() !== 4) begin
            errors++; $display("FAIL basic_count: got %0d required 4", cap_a.size());
        end
        for (int k = 0; k < cap_a.size() && k < 4; k++) begin
            checks++;
            if (cap_a[k] !== exp4(0, 2 + k/2, 2 + k%2) || idx_a[k] !== (2 + k/2)*4 + 2 + k%2
                || fd_a[k] !== (k == 3)) begin
                errors++;
                $display("FAIL basic_win%0d: got %h idx %0d fd %0d required %h idx %0d fd %0d",
                         k, cap_a[k], idx_a[k], fd_a[k], exp4(0, 2 + k/2, 2 + k%2),
                         (2 + k/2)*4 + 2 + k%2, k == 3);
            end
        end
        if (cap_a.size() == 4) begin
            checks++;
            if (cap_a[0] !== pk_int(f) || cap_a[3] !== pk_int(l)) begin
                errors++;
                $display("FAIL basic_first_last: got %h %h required %h %h",
                         cap_a[0], cap_a[3], pk_int(f), pk_int(l));
            end
        end
    endtask

    task automatic test_gapped();
        logic [53:0] prev;
        clear_a();
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, i == 0, i);
            prev = pk(wa);
            step_a(1'b0, 1'b0, 0);
            checks++;
            if (win_valid_a !== 1'b0 || frame_done_a !== 1'b0 || pk(wa) !== prev) begin
                errors++;
                $display("FAIL gap_hold%0d: got v=%b fd=%b win %h required 0 0 %h",
                         i, win_valid_a, frame_done_a, pk(wa), prev);
            end
        end
        checks++;
        if (cap_a.size() !== 4) begin
            errors++; $display("FAIL gap_count: got %0d required 4", cap_a.size());
        end
        for (int k = 0; k < cap_a.size() && k < 4; k++) begin
            checks++;
            if (cap_a[k] !== exp4(0, 2 + k/2, 2 + k%2) || idx_a[k] !== (2 + k/2)*4 + 2 + k%2
                || fd_a[k] !== (k == 3)) begin
                errors++;
                $display("FAIL gap_win%0d: got %h idx %0d required %h idx %0d",
                         k, cap_a[k], idx_a[k], exp4(0, 2 + k/2, 2 + k%2), (2 + k/2)*4 + 2 + k%2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fifth [9] = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
        int fds;
        clear_a();
        for (int i = 0; i < 32; i++) step_a(1'b1, i == 0, i);
        step_a(1'b0, 1'b0, 0);
        checks++;
        if (cap_a.size() !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d required 8", cap_a.size());
        end
        fds = 0;
        for (int k = 0; k < cap_a.size() && k < 8; k++) begin
            fds += int'(fd_a[k]);
            checks++;
            if (cap_a[k] !== exp4(16*(k/4), 2 + (k%4)/2, 2 + k%2)) begin
                errors++;
                $display("FAIL b2b_win%0d: got %h required %h", k, cap_a[k],
                         exp4(16*(k/4), 2 + (k%4)/2, 2 + k%2));
            end
        end
        checks++;
        if (cap_a.size() < 5 || cap_a[4] !== pk_int(fifth) || fds !== 2) begin
            errors++;
            $display("FAIL b2b_fifth_fd: got %h fd %0d required %h fd 2",
                     cap_a.size() >= 5 ? cap_a[4] : 54'h0, fds, pk_int(fifth));
        end
    endtask

    task automatic test_sof_resync();
        clear_a();
        for (int i = 0; i < 6; i++) step_a(1'b1, 1'b0, 40 + i);
        checks++;
        if (cap_a.size() !== 0) begin
            errors++; $display("FAIL resync_partial: got %0d windows required 0", cap_a.size());
        end
        clear_a();
        send_frame_a(0, 1'b1);
        step_a(1'b0, 1'b0, 0);
        checks++;
        if (cap_a.size() !== 4) begin
            errors++; $display("FAIL resync_count: got %0d required 4", cap_a.size());
        end
        for (int k = 0; k < cap_a.size() && k < 4; k++) begin
            checks++;
            if (cap_a[k] !== exp4(0, 2 + k/2, 2 + k%2) || fd_a[k] !== (k == 3)) begin
                errors++;
                $display("FAIL resync_win%0d: got %h fd %0d required %h",
                         k, cap_a[k], fd_a[k], exp4(0, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_a();
        for (int i = 0; i < 9; i++) step_a(1'b1, i == 0, i);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({win_valid_a, frame_done_a, pk(wa)} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got v=%b fd=%b win %h required all zero",
                     win_valid_a, frame_done_a, pk(wa));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_a();
        send_frame_a(0, 1'b0);
        step_a(1'b0, 1'b0, 0);
        checks++;
        if (cap_a.size() !== 4) begin
            errors++; $display("FAIL reset_mid_count: got %0d required 4", cap_a.size());
        end
        for (int k = 0; k < cap_a.size() && k < 4; k++) begin
            checks++;
            if (cap_a[k] !== exp4(0, 2 + k/2, 2 + k%2) || idx_a[k] !== (2 + k/2)*4 + 2 + k%2
                || fd_a[k] !== (k == 3)) begin
                errors++;
                $display("FAIL reset_mid_win%0d: got %h idx %0d required %h idx %0d",
                         k, cap_a[k], idx_a[k], exp4(0, 2 + k/2, 2 + k%2), (2 + k/2)*4 + 2 + k%2);
            end
        end
    endtask

    task automatic test_default_size();
        int fds;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) img[r][c] = int'($urandom_range(63));
        cap_b.delete(); fd_b.delete(); idx_b.delete(); nacc_b = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) step_b(1'b1, r == 0 && c == 0, img[r][c]);
        step_b(1'b0, 1'b0, 0);
        checks++;
        if (cap_b.size() !== 900) begin
            errors++; $display("FAIL default_count: got %0d required 900", cap_b.size());
        end
        fds = 0;
        for (int k = 0; k < cap_b.size() && k < 900; k++) begin
            fds += int'(fd_b[k]);
            checks++;
            if (cap_b[k] !== exp32(2 + k/30, 2 + k%30) || idx_b[k] !== (2 + k/30)*32 + 2 + k%30
                || fd_b[k] !== (k == 899)) begin
                errors++;
                $display("FAIL default_win%0d: got %h idx %0d fd %0d required %h idx %0d",
                         k, cap_b[k], idx_b[k], fd_b[k], exp32(2 + k/30, 2 + k%30),
                         (2 + k/30)*32 + 2 + k%30);
            end
        end
        checks++;
        if (fds !== 1) begin
            errors++; $display("FAIL default_frame_done: got %0d pulses required 1", fds);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_sof_resync();
        test_reset_mid();
        test_default_size();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv33_window_gen.md
# conv33_window_gen

Streaming 3x3 window generator that feeds a 3x3 convolution engine's nine data inputs. It accepts one 6-bit pixel per cycle in raster order and buffers the two previous image rows in line buffers. Each time a full 3x3 neighbourhood is available, it presents that neighbourhood as nine registered window outputs. It sits upstream of the convolution block and drives its `in_data_0..in_data_8` inputs; kernel loading is out of scope.

## Interface
- `IMG_W`, default 32: image width in pixels; must be ≥3.
- `IMG_H`, default 32: image height in rows; must be ≥3.
- `DW`, default 6: pixel width in bits.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `pix_in` input, DW bits: incoming pixel.
- `pix_valid` input, 1 bit: `pix_in` is accepted on this cycle. There is no backpressure; every valid pixel is consumed.
- `sof` input, 1 bit: start of frame. Only meaningful when `pix_valid`=1.
- `win_0` … `win_8` output, DW bits each: window in row-major order.
  - `win_0` = top-left (oldest row, oldest column).
  - `win_8` = bottom-right (the newest pixel).
- `win_valid` output, 1 bit: one-cycle pulse; `win_*` holds a new complete window.
- `frame_done` output, 1 bit: one-cycle pulse, coincident with the last window of a frame.

## Operation
- **Counters:** `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1. They give the position of the next pixel to be accepted. The counters advance only on an accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - After (row=IMG_H-1, col=IMG_W-1), both counters wrap to 0.
- **sof:** if `sof`=1 with `pix_valid`=1, that pixel is taken as position (0,0), regardless of the counter values. After it, the counters become (0,1). This resynchronises mid-frame.
- **Line buffers:** two buffers, `lb0` (previous row) and `lb1` (row before that), each IMG_W entries, indexed by `col`. On an accepted pixel:
  - `lb1[col]` ← `lb0[col]`
  - `lb0[col]` ← `pix_in`
  - Line buffer contents are not reset; the valid qualification below makes stale data unobservable.
- **Window shift register:** three columns of three pixels. On an accepted pixel, the columns shift left by one. The new right column, top to bottom, is {`lb1[col]`, `lb0[col]`, `pix_in`}, using pre-update buffer values.
- **Window qualification:** a pixel accepted at (row≥2, col≥2) completes a window.
  - Next cycle: `win_valid`=1 and `win_*` show that window.
  - Otherwise `win_valid`=0.
- **Window count:** exactly (IMG_H-2)·(IMG_W-2) windows per frame. There is no padding, and no window spans a row wrap.
- **frame_done:** asserted together with `win_valid` for the window completed by pixel (IMG_H-1, IMG_W-1).
- **Idle cycles:** when `pix_valid`=0, no state changes. `win_*` hold their last values, and `win_valid` and `frame_done` are 0.
- **Frame boundaries:** back-to-back frames are supported with no bubble. Rows 0–1 of the new frame never qualify, so no window mixes two frames.
- **sof without valid:** `sof` with `pix_valid`=0 is ignored.

## Timing
- **Reset:** asserting `rst` asynchronously clears to 0:
  - `col` and `row`;
  - the window registers and all `win_*`;
  - `win_valid` and `frame_done`.
  - After deassertion, the first accepted pixel is at (0,0).
- **Latency:** 1 cycle from the accepting edge of the completing pixel to `win_valid`/`win_*`. Outputs are registered, with no combinational path from `pix_in` to `win_*`.
- **Throughput:** one window per cycle at most. Sustained rate equals the pixel rate within qualifying columns.
- **Reset mid-frame:** the partial frame is discarded. No `win_valid` is produced from pre-reset pixels.

## Test plan
1. **Basic 4x4 frame.** IMG_W=IMG_H=4; send `sof` with pixel 0, then pixels 1..15 back-to-back (value = row·4+col). Required response:
   - `win_valid` pulses exactly 4 times, one cycle after pixels 10, 11, 14 and 15.
   - First window: {0,1,2,4,5,6,8,9,10}.
   - Last window: {5,6,7,9,10,11,13,14,15}.
   - `frame_done` is high only with the last window.
2. **Gapped input.** Same frame with `pix_valid` toggling every cycle. Required response: the same 4 windows; each `win_valid` is 1 cycle after its qualifying accept; `win_*` stay stable across gaps.
3. **Back-to-back frames.** Send pixels 0..15, then 16..31 without a gap; `sof` is on pixel 0 only. Required response:
   - 8 windows in total.
   - Fifth window: {16,17,18,20,21,22,24,25,26}.
   - `frame_done` pulses twice.
4. **sof resync.** Send 6 pixels, then a full frame starting with `sof`. Required response: exactly the 4 windows of scenario 1, with none from the partial data.
5. **Reset mid-frame.** Assert `rst` after 9 pixels of a 4x4 frame. Required response:
   - All outputs go to 0 immediately.
   - After release, a full frame yields scenario 1 results exactly.
6. **Default size.** IMG_W=IMG_H=32 with random pixels. Required response: 900 windows, each matching a reference model, and `frame_done` exactly once.
